// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared definitions for the byte-serial memory controller.
//   - size codes used by load/store requesters
//   - FSM state and request-owner encodings
//   - default IO threshold and fetch length
//   - size_to_len(): maps a size code to a byte count (1/2/4)
package mem_ctrl_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [31:0] IO_THRESHOLD_DEF = 32'h0003_0000;
  localparam int          FETCH_LEN_DEF    = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_LOAD  = 2'd2,
    OWN_STORE = 2'd3
  } owner_e;

  // Size code 3 is illegal and is treated as a full word.
  function automatic logic [2:0] size_to_len(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_arbiter.sv
// mem_arbiter: combinational fixed-priority grant, store > load > fetch.
// Ports:
//   en         in   1  grant allowed this cycle (idle, no rollback, no done pulse high)
//   store_req  in   1  committed store request
//   load_req   in   1  load request
//   fetch_req  in   1  instruction fetch request
//   gnt_valid  out  1  a request is granted this cycle
//   gnt_owner  out  2  owner of the granted request (OWN_NONE when none)
module mem_arbiter
  import mem_ctrl_pkg::*;
(
  input  logic   en,
  input  logic   store_req,
  input  logic   load_req,
  input  logic   fetch_req,
  output logic   gnt_valid,
  output owner_e gnt_owner
);

  always_comb begin
    gnt_valid = 1'b0;
    gnt_owner = OWN_NONE;
    if (en) begin
      if (store_req) begin
        gnt_valid = 1'b1;
        gnt_owner = OWN_STORE;
      end else if (load_req) begin
        gnt_valid = 1'b1;
        gnt_owner = OWN_LOAD;
      end else if (fetch_req) begin
        gnt_valid = 1'b1;
        gnt_owner = OWN_FETCH;
      end
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: shares one 8-bit RAM/IO port between instruction fetch, LSB loads
// and ROB committed stores. Each request is serialised into 1/2/4 byte
// accesses; reads return little-endian assembled data, writes a finish pulse.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   rdy                   global ready; low freezes every register
//   rollback              mispredict flush (aborts reads, never stores)
//   fetch_req/addr        fetch request -> fetch_done pulse + fetch_inst
//   load_req/addr/size    load request  -> load_done pulse + load_data
//   store_req/addr/size/data  store request -> finish_store pulse
//   mem_din               RAM read byte (one-cycle registered latency)
//   mem_dout/mem_a/mem_wr RAM write byte, byte address, write enable
//   io_buffer_full        back-pressure for writes at or above IO_THRESHOLD
//   dbg_state             current FSM state, for observation only
//
// Requester handshake: a requester holds its req level (and its address,
// size and data) until it sees its one-cycle done pulse; in that pulse cycle
// no new grant is made, which gives the requester one cycle to drop req.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [31:0] IO_THRESHOLD = IO_THRESHOLD_DEF,
  parameter int          FETCH_LEN    = FETCH_LEN_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        rollback,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_done,
  output logic [31:0] fetch_inst,
  input  logic        load_req,
  input  logic [31:0] load_addr,
  input  logic [1:0]  load_size,
  output logic        load_done,
  output logic [31:0] load_data,
  input  logic        store_req,
  input  logic [31:0] store_addr,
  input  logic [1:0]  store_size,
  input  logic [31:0] store_data,
  output logic        finish_store,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  output logic [1:0]  dbg_state
);

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  logic [31:0] base_q, base_d;
  logic [2:0]  len_q, len_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] sdata_q, sdata_d;
  logic [31:0] buf_q, buf_d;
  logic        fetch_done_q, fetch_done_d;
  logic [31:0] fetch_inst_q, fetch_inst_d;
  logic        load_done_q, load_done_d;
  logic [31:0] load_data_q, load_data_d;
  logic        finish_store_q, finish_store_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;

  logic        pulse_busy;
  logic        arb_en;
  logic        gnt_valid;
  owner_e      gnt_owner;
  logic [2:0]  cnt_m1;
  logic [2:0]  rd_next;
  logic [31:0] rd_next_addr;
  logic [31:0] wr_addr;

  assign pulse_busy   = fetch_done_q | load_done_q | finish_store_q;
  assign arb_en       = (state_q == ST_IDLE) && !rollback && !pulse_busy;
  assign cnt_m1       = cnt_q - 3'd1;
  assign rd_next      = cnt_q + 3'd1;
  assign rd_next_addr = base_q + {29'd0, rd_next};
  assign wr_addr      = base_q + {29'd0, cnt_q};

  mem_arbiter u_arb (
    .en        (arb_en),
    .store_req (store_req),
    .load_req  (load_req),
    .fetch_req (fetch_req),
    .gnt_valid (gnt_valid),
    .gnt_owner (gnt_owner)
  );

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    base_d         = base_q;
    len_d          = len_q;
    cnt_d          = cnt_q;
    sdata_d        = sdata_q;
    buf_d          = buf_q;
    fetch_done_d   = 1'b0;
    fetch_inst_d   = fetch_inst_q;
    load_done_d    = 1'b0;
    load_data_d    = load_data_q;
    finish_store_d = 1'b0;
    mem_a_d        = mem_a_q;
    mem_dout_d     = mem_dout_q;
    mem_wr_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          owner_d = gnt_owner;
          buf_d   = 32'd0;
          case (gnt_owner)
            OWN_STORE: begin
              state_d = ST_WRITE;
              base_d  = store_addr;
              len_d   = size_to_len(store_size);
              sdata_d = store_data;
              mem_a_d = store_addr;
              // Byte 0 goes out on the grant edge unless the IO buffer is full.
              if ((store_addr >= IO_THRESHOLD) && io_buffer_full) begin
                cnt_d = 3'd0;
              end else begin
                mem_dout_d = store_data[7:0];
                mem_wr_d   = 1'b1;
                cnt_d      = 3'd1;
              end
            end
            OWN_LOAD: begin
              state_d = ST_READ;
              base_d  = load_addr;
              len_d   = size_to_len(load_size);
              mem_a_d = load_addr;
              cnt_d   = 3'd0;
            end
            default: begin
              state_d = ST_READ;
              base_d  = fetch_addr;
              len_d   = 3'(FETCH_LEN);
              mem_a_d = fetch_addr;
              cnt_d   = 3'd0;
            end
          endcase
        end
      end

      // cnt_q is the index of the byte whose address is currently on mem_a;
      // the RAM answers one edge later, so byte cnt_q-1 is captured now.
      ST_READ: begin
        if (rollback) begin
          state_d = ST_IDLE;
          mem_a_d = 32'd0;
          cnt_d   = 3'd0;
        end else begin
          if (cnt_q != 3'd0) begin
            buf_d[{cnt_m1[1:0], 3'b000} +: 8] = mem_din;
          end
          if (cnt_q == len_q) begin
            state_d = ST_IDLE;
            mem_a_d = 32'd0;
            cnt_d   = 3'd0;
            if (owner_q == OWN_LOAD) begin
              load_data_d = buf_d;
              load_done_d = 1'b1;
            end else begin
              fetch_inst_d = buf_d;
              fetch_done_d = 1'b1;
            end
          end else begin
            cnt_d   = rd_next;
            mem_a_d = (rd_next < len_q) ? rd_next_addr : 32'd0;
          end
        end
      end

      // cnt_q is the index of the next byte to put on the bus.
      ST_WRITE: begin
        if (cnt_q == len_q) begin
          state_d        = ST_IDLE;
          finish_store_d = 1'b1;
          mem_a_d        = 32'd0;
          cnt_d          = 3'd0;
        end else if ((wr_addr >= IO_THRESHOLD) && io_buffer_full) begin
          mem_a_d = wr_addr;
        end else begin
          mem_a_d    = wr_addr;
          mem_dout_d = sdata_q[{cnt_q[1:0], 3'b000} +: 8];
          mem_wr_d   = 1'b1;
          cnt_d      = rd_next;
        end
      end

      default: begin
        state_d = ST_IDLE;
        mem_a_d = 32'd0;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      owner_q        <= OWN_NONE;
      base_q         <= 32'd0;
      len_q          <= 3'd0;
      cnt_q          <= 3'd0;
      sdata_q        <= 32'd0;
      buf_q          <= 32'd0;
      fetch_done_q   <= 1'b0;
      fetch_inst_q   <= 32'd0;
      load_done_q    <= 1'b0;
      load_data_q    <= 32'd0;
      finish_store_q <= 1'b0;
      mem_a_q        <= 32'd0;
      mem_dout_q     <= 8'd0;
      mem_wr_q       <= 1'b0;
    end else if (rdy) begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      base_q         <= base_d;
      len_q          <= len_d;
      cnt_q          <= cnt_d;
      sdata_q        <= sdata_d;
      buf_q          <= buf_d;
      fetch_done_q   <= fetch_done_d;
      fetch_inst_q   <= fetch_inst_d;
      load_done_q    <= load_done_d;
      load_data_q    <= load_data_d;
      finish_store_q <= finish_store_d;
      mem_a_q        <= mem_a_d;
      mem_dout_q     <= mem_dout_d;
      mem_wr_q       <= mem_wr_d;
    end
  end

  assign fetch_done   = fetch_done_q;
  assign fetch_inst   = fetch_inst_q;
  assign load_done    = load_done_q;
  assign load_data    = load_data_q;
  assign finish_store = finish_store_q;
  assign mem_a        = mem_a_q;
  assign mem_dout     = mem_dout_q;
  assign mem_wr       = mem_wr_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed bench for mem_ctrl with a byte RAM model, an expected
// response queue filled by the stimulus and a monitor that pops on each pulse.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam logic [1:0] K_FETCH = 2'd0;
  localparam logic [1:0] K_LOAD  = 2'd1;
  localparam logic [1:0] K_STORE = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        rdy = 1'b1, rollback = 1'b0;
  logic        fetch_req = 1'b0, load_req = 1'b0, store_req = 1'b0;
  logic [31:0] fetch_addr = '0, load_addr = '0, store_addr = '0, store_data = '0;
  logic [1:0]  load_size = '0, store_size = '0;
  logic        io_buffer_full = 1'b0;
  logic [7:0]  mem_din = '0;
  logic        fetch_done, load_done, finish_store, mem_wr;
  logic [31:0] fetch_inst, load_data, mem_a;
  logic [7:0]  mem_dout;
  logic [1:0]  dbg_state;

  mem_ctrl dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .rollback(rollback),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_done(fetch_done), .fetch_inst(fetch_inst),
    .load_req(load_req), .load_addr(load_addr), .load_size(load_size), .load_done(load_done), .load_data(load_data),
    .store_req(store_req), .store_addr(store_addr), .store_size(store_size), .store_data(store_data),
    .finish_store(finish_store), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full), .dbg_state(dbg_state)
  );

  // ---------------- RAM model (paused while rdy is low) ----------------
  logic [7:0] ram [logic [31:0]];
  int wr_cnt = 0;
  always @(posedge clk) begin
    if (rdy) begin
      mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
      if (mem_wr) begin
        ram[mem_a] = mem_dout;
        wr_cnt++;
      end
    end
  end

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? {24'd0, ram[a]} : 32'd0;
  endfunction

  // ---------------- scoreboard ----------------
  logic [33:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic pop_cmp(input logic [1:0] kind, input logic [31:0] data);
    logic [33:0] e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL sb_unexpected: got pulse kind %0d data 0x%08h expected no pulse", kind, data);
    end else begin
      e = exp_q.pop_front();
      check("sb_kind", {30'd0, kind}, {30'd0, e[33:32]});
      check("sb_data", data, e[31:0]);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (finish_store) pop_cmp(K_STORE, 32'd0);
      if (load_done)    pop_cmp(K_LOAD, load_data);
      if (fetch_done)   pop_cmp(K_FETCH, fetch_inst);
    end
  end

  // ---------------- driver tasks ----------------
  logic [31:0] a_log[$];
  logic        w_log[$];
  int          cyc;

  task automatic step();
    @(negedge clk);
    cyc++;
    a_log.push_back(mem_a);
    w_log.push_back(mem_wr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
    a_log.delete();
    w_log.delete();
    cyc = 0;
  endtask

  function automatic logic pulse_of(input logic [1:0] kind);
    case (kind)
      K_FETCH: return fetch_done;
      K_LOAD:  return load_done;
      default: return finish_store;
    endcase
  endfunction

  task automatic run_until(input logic [1:0] kind, input int max_cyc, output int at);
    at = -1;
    for (int i = 0; i < max_cyc; i++) begin
      step();
      if (pulse_of(kind)) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: got no pulse kind %0d within %0d cycles, expected one", kind, max_cyc);
    end
  endtask

  function automatic int count_wr();
    int n = 0;
    foreach (w_log[i]) if (w_log[i]) n++;
    return n;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100us");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int at, t_s, t_l, t_f, w0;
    repeat (2) @(negedge clk);
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_outs", {26'd0, fetch_done, load_done, finish_store, mem_wr, dbg_state}, 32'd0);
    check("rst_data", fetch_inst | load_data | {24'd0, mem_dout}, 32'd0);
    rst_n = 1'b1;

    // 1) fetch 0x1000
    ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h05; ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h00;
    idle(2);
    fetch_addr = 32'h1000; fetch_req = 1'b1;
    exp_q.push_back({K_FETCH, 32'h0000_0513});
    run_until(K_FETCH, 20, at);
    fetch_req = 1'b0;
    check("fetch_latency", at, 6);
    check("fetch_a0", a_log[0], 32'h1000);
    check("fetch_a3", a_log[3], 32'h1003);
    check("fetch_no_wr", count_wr(), 0);

    // 2) store + load + fetch in the same cycle
    idle(2);
    store_addr = 32'h100; store_size = SZ_W; store_data = 32'hDEAD_BEEF; store_req = 1'b1;
    load_addr = 32'h100; load_size = SZ_W; load_req = 1'b1;
    fetch_addr = 32'h1000; fetch_req = 1'b1;
    exp_q.push_back({K_STORE, 32'd0});
    exp_q.push_back({K_LOAD, 32'hDEAD_BEEF});
    exp_q.push_back({K_FETCH, 32'h0000_0513});
    t_s = -1; t_l = -1; t_f = -1;
    for (int i = 0; i < 60 && (t_s < 0 || t_l < 0 || t_f < 0); i++) begin
      step();
      if (finish_store) begin t_s = cyc; store_req = 1'b0; end
      if (load_done)    begin t_l = cyc; load_req = 1'b0; end
      if (fetch_done)   begin t_f = cyc; fetch_req = 1'b0; end
    end
    store_req = 1'b0; load_req = 1'b0; fetch_req = 1'b0;
    check("prio_store_at", t_s, 5);
    check("prio_load_at", t_l, 12);
    check("prio_fetch_at", t_f, 19);
    check("prio_wr_cycles", count_wr(), 4);

    // 3) 2-byte load at 0x2003
    ram[32'h2003] = 8'hAB; ram[32'h2004] = 8'hCD;
    idle(2);
    load_addr = 32'h2003; load_size = SZ_H; load_req = 1'b1;
    exp_q.push_back({K_LOAD, 32'h0000_CDAB});
    run_until(K_LOAD, 20, at);
    load_req = 1'b0;
    check("lh_latency", at, 4);
    check("lh_a0", a_log[0], 32'h2003);
    check("lh_a1", a_log[1], 32'h2004);

    // 4) IO byte store with back-pressure for 3 cycles
    idle(2);
    w0 = wr_cnt;
    store_addr = 32'h0003_0000; store_size = SZ_B; store_data = 32'h9988_7741; store_req = 1'b1;
    io_buffer_full = 1'b1;
    exp_q.push_back({K_STORE, 32'd0});
    repeat (3) step();
    io_buffer_full = 1'b0;
    run_until(K_STORE, 10, at);
    store_req = 1'b0;
    check("io_finish_at", at, 5);
    check("io_stall_wr", {29'd0, w_log[0], w_log[1], w_log[2]}, 32'd0);
    check("io_stall_addr", a_log[0], 32'h0003_0000);
    check("io_write_cycle", {31'd0, w_log[3]}, 32'd1);
    check("io_write_count", wr_cnt - w0, 1);
    check("io_ram_byte", ram_rd(32'h0003_0000), 32'h41);

    // 5) rollback on the 2nd edge of a 4-byte load, store raised meanwhile
    idle(2);
    load_addr = 32'h100; load_size = SZ_W; load_req = 1'b1;
    step();
    rollback = 1'b1; load_req = 1'b0;
    store_addr = 32'h200; store_size = SZ_B; store_data = 32'h0000_0055; store_req = 1'b1;
    exp_q.push_back({K_STORE, 32'd0});
    step();
    check("rb_state_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    check("rb_mem_a", mem_a, 32'd0);
    rollback = 1'b0;
    run_until(K_STORE, 10, at);
    store_req = 1'b0;
    check("rb_store_at", at, 4);
    check("rb_ram_byte", ram_rd(32'h200), 32'h55);
    check("rb_load_hold", load_data, 32'h0000_CDAB);

    // 6) rdy low for 2 cycles mid 4-byte store
    idle(2);
    w0 = wr_cnt;
    store_addr = 32'h300; store_size = SZ_W; store_data = 32'h1122_3344; store_req = 1'b1;
    exp_q.push_back({K_STORE, 32'd0});
    step();
    step();
    rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("frz_mem_a", mem_a, 32'h301);
      check("frz_dout_wr", {23'd0, mem_wr, mem_dout}, {23'd0, 1'b1, 8'h33});
    end
    rdy = 1'b1;
    run_until(K_STORE, 20, at);
    store_req = 1'b0;
    check("frz_finish_at", at, 7);
    check("frz_write_count", wr_cnt - w0, 4);
    idle(2);
    load_addr = 32'h300; load_size = 2'd3; load_req = 1'b1;
    exp_q.push_back({K_LOAD, 32'h1122_3344});
    run_until(K_LOAD, 20, at);
    load_req = 1'b0;
    check("frz_load_at", at, 6);

    // 7) reset mid-store: immediate idle with outputs cleared
    idle(2);
    store_addr = 32'h400; store_size = SZ_W; store_data = 32'hAABB_CCDD; store_req = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    store_req = 1'b0;
    #1;
    check("arst_outs", {25'd0, mem_wr, dbg_state, fetch_done, load_done, finish_store, 1'b0}, 32'd0);
    check("arst_mem_a", mem_a, 32'd0);
    check("arst_data", fetch_inst | load_data | {24'd0, mem_dout}, 32'd0);
    idle(1);
    rst_n = 1'b1;
    idle(3);
    check("sb_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
